// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output driver sharing one prescaler, step counter and duty shadow.
// Per-bit enables select off / static high / PWM; out is registered.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic [7:0]  step_cnt;
  logic [7:0]  duty_shadow;
  logic        tick;
  logic        boundary;
  logic        pwm_level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;

  assign tick     = (pre_cnt == PRE_MAX);
  assign boundary = tick && (step_cnt == 8'hFF);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (tick) begin
      step_cnt <= step_cnt + 8'd1;
    end
  end

  // Duty only changes at the period boundary so a period is never cut short or stretched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (boundary) begin
        duty_shadow <= pwm_duty_cycle;
      end
    end
  end

  assign pwm_level = (duty_shadow == 8'hFF) || (step_cnt < duty_shadow);

  assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  // Enabled bits drive 1 in static mode and the shared PWM level in PWM mode.
  assign out_next = en_out & (~en_pwm | {16{pwm_level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= out_next;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: one instance with PRESCALE=1 and one with PRESCALE=13
// share all inputs; each test task checks its own outputs against hand-derived values.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  eo_lo = '0, eo_hi = '0, ep_lo = '0, ep_hi = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out_p1, out_p13;
  logic        ps_p1, ps_p13;

  int vectors = 0;
  int miscompares = 0;

  pwm_peripheral #(.PRESCALE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out_p1), .period_start(ps_p1)
  );

  pwm_peripheral #(.PRESCALE(13)) u_p13 (
    .clk(clk), .rst_n(rst_n),
    .en_reg_out_7_0(eo_lo), .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0(ep_lo), .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle(duty), .out(out_p13), .period_start(ps_p13)
  );

  always #5 clk = ~clk;

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    eo_lo = eo[7:0];
    eo_hi = eo[15:8];
    ep_lo = ep[7:0];
    ep_hi = ep[15:8];
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts negedges until the chosen instance shows period_start, bounded by budget.
  task automatic wait_ps(input bit use_p13, input int budget, output bit found, output int cycles);
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((use_p13 ? ps_p13 : ps_p1) === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    set_en(16'hFFFF, 16'hFFFF);
    duty  = 8'hFF;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (out_p1 !== 16'h0000 || out_p13 !== 16'h0000 || ps_p1 !== 1'b0 || ps_p13 !== 1'b0) begin
        miscompares++;
        $display("FAIL reset[%0d]: out_p1=%h out_p13=%h ps=%b%b, want 0000 0000 00",
                 i, out_p1, out_p13, ps_p1, ps_p13);
      end
    end
  endtask

  task automatic test_static();
    set_en(16'h0000, 16'h0000);
    duty = 8'h00;
    do_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if (out_p1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL static_idle: got %h, want 0000", out_p1);
    end
    eo_lo = 8'hA5;
    #1;
    vectors++;
    if (out_p1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL static_not_early: got %h, want 0000", out_p1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (out_p1 !== 16'h00A5 || out_p13 !== 16'h00A5) begin
        miscompares++;
        $display("FAIL static_a5[%0d]: got %h/%h, want 00A5", i, out_p1, out_p13);
      end
    end
    // en_pwm bits without en_out must stay 0.
    eo_hi = 8'h3C;
    ep_lo = 8'h5A;
    @(negedge clk);
    vectors++;
    if (out_p1 !== 16'h3CA5) begin
      miscompares++;
      $display("FAIL static_hi: got %h, want 3CA5", out_p1);
    end
  endtask

  task automatic test_duty(input logic [7:0] d);
    bit   found;
    int   cyc;
    logic exp_o, exp_ps;
    set_en(16'h0001, 16'h0001);
    duty = d;
    do_reset();
    wait_ps(1'b0, 600, found, cyc);
    vectors++;
    if (!found || cyc != 256) begin
      miscompares++;
      $display("FAIL duty_%h_first_ps: found=%0b after %0d clk, want 1 after 256", d, found, cyc);
    end
    for (int k = 1; k <= 512; k++) begin
      @(negedge clk);
      exp_o  = (d == 8'hFF) ? 1'b1 : (((k - 1) % 256) < int'(d));
      exp_ps = ((k % 256) == 0);
      vectors++;
      if (out_p1[0] !== exp_o || ps_p1 !== exp_ps) begin
        miscompares++;
        $display("FAIL duty_%h k=%0d: out0=%b ps=%b, want out0=%b ps=%b",
                 d, k, out_p1[0], ps_p1, exp_o, exp_ps);
      end
    end
  endtask

  task automatic test_shadow();
    bit found;
    int cyc;
    int high1 = 0;
    int high2 = 0;
    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    do_reset();
    wait_ps(1'b1, 4000, found, cyc);
    vectors++;
    if (!found || cyc != 3328) begin
      miscompares++;
      $display("FAIL shadow_first_ps: found=%0b after %0d clk, want 1 after 3328", found, cyc);
    end
    for (int k = 1; k <= 6656; k++) begin
      @(negedge clk);
      if (k <= 3328) high1 += int'(out_p13[0]);
      else           high2 += int'(out_p13[0]);
      if (k == 500) duty = 8'h20;
      if (k == 3327 || k == 3328 || k == 6656) begin
        vectors++;
        if (ps_p13 !== (k != 3327)) begin
          miscompares++;
          $display("FAIL shadow_ps k=%0d: got %b, want %b", k, ps_p13, (k != 3327));
        end
      end
    end
    vectors++;
    if (high1 != 1664) begin
      miscompares++;
      $display("FAIL shadow_high_cur: got %0d, want 1664", high1);
    end
    vectors++;
    if (high2 != 416) begin
      miscompares++;
      $display("FAIL shadow_high_next: got %0d, want 416", high2);
    end
  endtask

  task automatic test_midop_reset();
    bit   found;
    int   cyc;
    logic exp_o;
    set_en(16'h0001, 16'h0001);
    duty = 8'h80;
    do_reset();
    wait_ps(1'b0, 600, found, cyc);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midop_ps: not seen within 600 clk, want seen");
    end
    repeat (100) @(negedge clk);
    vectors++;
    if (out_p1[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_pre: out0=%b, want 1", out_p1[0]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_p1 !== 16'h0000 || ps_p1 !== 1'b0 || out_p13 !== 16'h0000) begin
      miscompares++;
      $display("FAIL midop_async: out_p1=%h ps=%b out_p13=%h, want 0000 0 0000", out_p1, ps_p1, out_p13);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      @(negedge clk);
      vectors++;
      if (out_p1[0] !== 1'b0 || ps_p1 !== (c == 256)) begin
        miscompares++;
        $display("FAIL midop_restart c=%0d: out0=%b ps=%b, want 0 %b", c, out_p1[0], ps_p1, (c == 256));
      end
    end
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      exp_o = (k - 1) < 128;
      vectors++;
      if (out_p1[0] !== exp_o) begin
        miscompares++;
        $display("FAIL midop_duty k=%0d: out0=%b, want %b", k, out_p1[0], exp_o);
      end
    end
  endtask

  task automatic test_enable_midperiod();
    bit          found;
    int          cyc;
    logic [15:0] exp_out;
    bit          do_chk;
    set_en(16'h0001, 16'h0000);
    duty = 8'h80;
    do_reset();
    wait_ps(1'b0, 600, found, cyc);
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL enable_ps: not seen within 600 clk, want seen");
    end
    set_en(16'hFFFF, 16'h0000);
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      do_chk  = 1'b1;
      exp_out = 16'h0000;
      case (k)
        1:       exp_out = 16'hFFFF;
        11:      exp_out = 16'hFFFF;
        130:     exp_out = 16'h0000;
        141:     exp_out = 16'hFF00;
        151:     exp_out = 16'hFF00;
        260:     exp_out = 16'hFF0F;
        default: do_chk  = 1'b0;
      endcase
      if (do_chk) begin
        vectors++;
        if (out_p1 !== exp_out) begin
          miscompares++;
          $display("FAIL enable k=%0d: got %h, want %h", k, out_p1, exp_out);
        end
      end
      if (k == 10)  set_en(16'hFFFF, 16'hFFFF);
      if (k == 140) set_en(16'hFFFF, 16'h00FF);
      if (k == 150) set_en(16'hFF0F, 16'h00FF);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_duty(8'h40);
    test_duty(8'h00);
    test_duty(8'hFF);
    test_shadow();
    test_midop_reset();
    test_enable_midperiod();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
